risc16_fetch: RTL and testbench

Instruction fetch unit for the RISC-16 core. It drives the 16-bit ir and pc consumed by the control decoder. It issues word reads to instruction memory over a req/ack handshake and holds each fetched word until execute accepts it. It then computes the next pc from the decoder's branch code, the BEQ compare result, the 7-bit branch immediate and the JALR target.

---
 rtl/risc16_fetch_if.sv | 29 ++
 rtl/risc16_fetch.sv | 120 ++++++++++++
 tb/tb_risc16_fetch.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc16_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory read handshake plus the ir/pc and
// branch signals exchanged with the decoder/execute stage.
interface risc16_fetch_if #(
  parameter int IMM_W = 7
);
  logic             mem_req;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_rdata;
  logic             mem_ack;
  logic [15:0]      ir;
  logic [15:0]      pc;
  logic             ir_valid;
  logic             ir_accept;
  logic [1:0]       branch;
  logic             cmp_eq;
  logic [IMM_W-1:0] imm;
  logic [15:0]      jump_target;
  logic             halted;

  modport master (
    output mem_req, mem_addr, ir, pc, ir_valid, halted,
    input  mem_rdata, mem_ack, ir_accept, branch, cmp_eq, imm, jump_target
  );

  modport slave (
    input  mem_req, mem_addr, ir, pc, ir_valid, halted,
    output mem_rdata, mem_ack, ir_accept, branch, cmp_eq, imm, jump_target
  );
endinterface

// File: rtl/risc16_fetch.sv
// RISC-16 instruction fetch: req/ack word reads, holds ir until accepted, then
// computes next pc. Define RISC16_HALT_EN to build the HALTED state.
module risc16_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          IMM_W    = 7
) (
  input logic            clk,
  input logic            rst,
  risc16_fetch_if.master bus
);

`ifdef RISC16_HALT_EN
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] imm_ext;
  logic [15:0] pc_next;

  assign imm_ext = {{(16-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};

  always_comb begin
    pc_next = pc_q + 16'd1;
    case (bus.branch)
      2'b01:   pc_next = bus.jump_target;
      2'b10:   if (bus.cmp_eq) pc_next = pc_q + 16'd1 + imm_ext;
      default: ;
    endcase
  end

`ifdef RISC16_HALT_EN
  logic halted_q, halted_d;
  logic ir_is_halt;

  assign ir_is_halt = (ir_q[15:13] == 3'b111) && (ir_q[12:7] == '0) && (ir_q[6:0] != '0);
  assign bus.halted = halted_q;
`else
  assign bus.halted = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    mem_req_d  = mem_req_q;
`ifdef RISC16_HALT_EN
    halted_d   = halted_q;
`endif
    case (state_q)
      IDLE: begin
        state_d   = FETCH;
        mem_req_d = 1'b1;
      end
      FETCH: begin
        if (bus.mem_ack) begin
          ir_d       = bus.mem_rdata;
          ir_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (bus.ir_accept) begin
          ir_valid_d = 1'b0;
`ifdef RISC16_HALT_EN
          if (ir_is_halt) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else begin
            pc_d      = pc_next;
            mem_req_d = 1'b1;
            state_d   = FETCH;
          end
`else
          pc_d      = pc_next;
          mem_req_d = 1'b1;
          state_d   = FETCH;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      mem_req_q  <= 1'b0;
`ifdef RISC16_HALT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      mem_req_q  <= mem_req_d;
`ifdef RISC16_HALT_EN
      halted_q   <= halted_d;
`endif
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = pc_q;
  assign bus.ir       = ir_q;
  assign bus.pc       = pc_q;
  assign bus.ir_valid = ir_valid_q;

endmodule

// File: tb/tb_risc16_fetch.sv
// Bench for risc16_fetch: latency-programmable memory responder, a
// transaction-level pc/ir model checked every negedge, plus directed checks.
module tb_risc16_fetch;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          IMM_W    = 7;

  logic clk;
  logic rst;

  risc16_fetch_if #(.IMM_W(IMM_W)) bus();

  risc16_fetch #(.RESET_PC(RESET_PC), .IMM_W(IMM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: fixed pattern (top bits 001, never a halt word) plus one override.
  logic        ov_en;
  logic [15:0] ov_addr, ov_data;

  function automatic logic [15:0] memword(input logic [15:0] a);
    if (ov_en && a == ov_addr) return ov_data;
    return 16'h2485 ^ {3'b000, a[12:0]};
  endfunction

  function automatic logic is_halt_word(input logic [15:0] w);
`ifdef RISC16_HALT_EN
    return (w[15:13] == 3'b111) && (w[12:7] == 6'd0) && (w[6:0] != 7'd0);
`else
    return (w == 16'h0000) && (w != 16'h0000);
`endif
  endfunction

  // Responder drives memory inputs at posedge+2, after the main block's posedge+1 updates.
  int          lat;
  bit          resp_en;
  logic        man_ack;
  logic [15:0] man_rdata;

  initial begin
    int cnt;
    cnt           = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #2;
      if (!resp_en) begin
        cnt           = 0;
        bus.mem_ack   = man_ack;
        bus.mem_rdata = man_rdata;
      end else if (bus.mem_req) begin
        if (cnt >= lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = memword(bus.mem_addr);
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = 16'hDEAD;
        end
        cnt++;
      end else begin
        cnt           = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'hDEAD;
      end
    end
  end

  // Transaction model: expected pc advances by the branch rules on each accept.
  logic [15:0] m_pc;
  logic        m_halt;

  always @(negedge clk) begin
    int off;
    if (rst) begin
      m_pc   = RESET_PC;
      m_halt = 1'b0;
      chk1 ("m_rst_req",    bus.mem_req,  1'b0);
      chk1 ("m_rst_valid",  bus.ir_valid, 1'b0);
      chk1 ("m_rst_halted", bus.halted,   1'b0);
      chk16("m_rst_pc",     bus.pc,       RESET_PC);
      chk16("m_rst_ir",     bus.ir,       16'h0000);
    end else begin
      chk1("m_halted", bus.halted, m_halt);
      chk1("m_req_excl_valid", bus.mem_req & bus.ir_valid, 1'b0);
      if (bus.mem_req) chk16("m_addr", bus.mem_addr, m_pc);
      if (m_halt) begin
        chk1 ("m_halt_req", bus.mem_req, 1'b0);
        chk16("m_halt_pc",  bus.pc,      m_pc);
      end
      if (bus.ir_valid) begin
        chk16("m_pc", bus.pc, m_pc);
        chk16("m_ir", bus.ir, memword(m_pc));
        if (bus.ir_accept) begin
          if (is_halt_word(memword(m_pc))) begin
            m_halt = 1'b1;
          end else if (bus.branch == 2'b01) begin
            m_pc = bus.jump_target;
          end else if (bus.branch == 2'b10 && bus.cmp_eq) begin
            off = int'(bus.imm);
            if (bus.imm[IMM_W-1]) off -= (1 << IMM_W);
            m_pc = 16'(int'(m_pc) + 1 + off);
          end else begin
            m_pc = 16'(int'(m_pc) + 1);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one accepted cycle; returns at posedge+1 just after the accepting edge.
  task automatic accept_with(input logic [1:0] br, input logic eq,
                             input logic [IMM_W-1:0] im, input logic [15:0] jt);
    step();
    bus.ir_accept   = 1'b1;
    bus.branch      = br;
    bus.cmp_eq      = eq;
    bus.imm         = im;
    bus.jump_target = jt;
    step();
    bus.ir_accept   = 1'b0;
    bus.branch      = 2'b00;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (bus.ir_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1(name, bus.ir_valid, 1'b1);
  endtask

  task automatic next_addr(input string name, input logic [15:0] exp);
    @(negedge clk);
    chk1 ({name, "_req"}, bus.mem_req, 1'b1);
    chk16(name, bus.mem_addr, exp);
    wait_valid({name, "_valid"});
  endtask

  task automatic goto_pc(input logic [15:0] target);
    accept_with(2'b01, 1'b0, '0, target);
    next_addr("goto", target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.ir_accept   = 1'b1;
    bus.branch      = 2'b00;
    bus.cmp_eq      = 1'b0;
    bus.imm         = '0;
    bus.jump_target = 16'h0000;
    lat = 0; resp_en = 1'b1; man_ack = 1'b0; man_rdata = 16'h0000;
    ov_en = 1'b0; ov_addr = 16'h0000; ov_data = 16'h0000;

    // Reset release with zero-wait memory and accept held high.
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk1("idle_req", bus.mem_req, 1'b0);
    @(negedge clk);
    chk1 ("c1_req",   bus.mem_req,  1'b1);
    chk16("c1_addr",  bus.mem_addr, 16'h0000);
    chk1 ("c1_valid", bus.ir_valid, 1'b0);
    @(negedge clk);
    chk1 ("c2_valid", bus.ir_valid, 1'b1);
    chk16("c2_ir",    bus.ir,       16'h2485);
    chk16("c2_pc",    bus.pc,       16'h0000);
    @(negedge clk);
    chk1 ("c3_req",   bus.mem_req,  1'b1);
    chk16("c3_addr",  bus.mem_addr, 16'h0001);
    step();
    bus.ir_accept = 1'b0;
    wait_valid("park_valid");

    // Memory acks late: request held stable, no early ir_valid.
    lat = 3;
    accept_with(2'b00, 1'b0, '0, 16'h0000);
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1 ("late_req",   bus.mem_req,  1'b1);
      chk16("late_addr",  bus.mem_addr, 16'h0002);
      chk1 ("late_valid", bus.ir_valid, 1'b0);
    end
    @(negedge clk);
    chk1 ("late_valid_after", bus.ir_valid, 1'b1);
    chk16("late_ir",          bus.ir,       16'h2487);
    lat = 0;

    // BEQ taken / not taken, positive offset, branch code 11.
    goto_pc(16'h0010);
    accept_with(2'b10, 1'b1, 7'h7E, 16'h5555);
    next_addr("beq_taken", 16'h000F);
    goto_pc(16'h0010);
    accept_with(2'b10, 1'b0, 7'h7E, 16'h5555);
    next_addr("beq_not_taken", 16'h0011);
    accept_with(2'b10, 1'b1, 7'h3F, 16'h5555);
    next_addr("beq_max_pos", 16'h0051);
    accept_with(2'b11, 1'b1, 7'h3F, 16'h5555);
    next_addr("branch_11_seq", 16'h0052);

    // JALR and wrap-around both ways.
    goto_pc(16'h0004);
    accept_with(2'b01, 1'b0, '0, 16'hABCD);
    next_addr("jalr", 16'hABCD);
    goto_pc(16'hFFFF);
    accept_with(2'b00, 1'b0, '0, 16'h1111);
    next_addr("seq_wrap", 16'h0000);
    accept_with(2'b10, 1'b1, 7'h7E, 16'h1111);
    next_addr("beq_neg_wrap", 16'hFFFF);
    accept_with(2'b10, 1'b1, 7'h40, 16'h1111);
    next_addr("beq_max_neg", 16'hFFC0);

    // Hold with no accept.
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk);
      chk16("hold_ir",    bus.ir,       memword(16'hFFC0));
      chk16("hold_pc",    bus.pc,       16'hFFC0);
      chk1 ("hold_req",   bus.mem_req,  1'b0);
      chk1 ("hold_valid", bus.ir_valid, 1'b1);
    end

    // Reset mid-fetch, then an ack that arrives while idle.
    lat = 5;
    accept_with(2'b00, 1'b0, '0, 16'h0000);
    @(negedge clk);
    chk1 ("mid_req", bus.mem_req,  1'b1);
    chk16("mid_addr", bus.mem_addr, 16'hFFC1);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk1 ("rst_async_req",   bus.mem_req,  1'b0);
    chk16("rst_async_pc",    bus.pc,       RESET_PC);
    chk1 ("rst_async_valid", bus.ir_valid, 1'b0);
    step();
    resp_en = 1'b0; man_ack = 1'b1; man_rdata = 16'h1234;
    step();
    rst = 1'b0;
    step();
    man_ack = 1'b0;
    lat = 0;
    resp_en = 1'b1;
    @(negedge clk);
    chk16("stale_ack_ir",    bus.ir,       16'h0000);
    chk1 ("stale_ack_valid", bus.ir_valid, 1'b0);
    chk1 ("stale_ack_req",   bus.mem_req,  1'b1);
    chk16("stale_ack_addr",  bus.mem_addr, RESET_PC);
    wait_valid("post_rst_valid");
    chk16("post_rst_ir", bus.ir, 16'h2485);

    // Halt encoding.
    ov_en = 1'b1; ov_addr = 16'h0100; ov_data = 16'hE001;
    goto_pc(16'h0100);
    chk16("halt_word_ir", bus.ir, 16'hE001);
    accept_with(2'b01, 1'b0, '0, 16'h0200);
`ifdef RISC16_HALT_EN
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1 ("halted",       bus.halted,   1'b1);
      chk16("halted_pc",    bus.pc,       16'h0100);
      chk1 ("halted_req",   bus.mem_req,  1'b0);
      chk1 ("halted_valid", bus.ir_valid, 1'b0);
    end
`else
    @(negedge clk);
    chk1 ("nohalt_halted", bus.halted,   1'b0);
    chk1 ("nohalt_req",    bus.mem_req,  1'b1);
    chk16("nohalt_addr",   bus.mem_addr, 16'h0200);
    wait_valid("nohalt_valid");
    chk16("nohalt_pc", bus.pc, 16'h0200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
